// File: rtl/tri_pwm_deadtime.sv
// Center-aligned complementary PWM with dead time, valley-synchronised duty shadowing and triangle-sequence checking.
// Optional build macro TRI_PWM_FAULT_SHUTDOWN_EN forces both outputs off after a sequence error until reset.
module tri_pwm_deadtime #(
   parameter int unsigned CW   = 3,
   parameter int unsigned PEAK = 3,
   parameter int unsigned DT   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt_in,
   input  logic [CW:0]   duty_in,
   input  logic          duty_wr,
   output logic          pwm_h,
   output logic          pwm_l,
   output logic          period_start,
   output logic          seq_err
);

   localparam logic [CW:0] DUTY_MAX = (CW+1)'(PEAK + 1);
   localparam logic [CW:0] PEAK_V   = (CW+1)'(PEAK);
   localparam logic [2:0]  DT_V     = 3'(DT);

   typedef enum logic [1:0] {OFF, HIGH, LOW, DEAD} state_t;

   state_t        state, state_nx;
   logic          target, target_nx;
   logic [2:0]    dt_cnt, dt_cnt_nx;
   logic [CW:0]   duty_pend, duty_act, duty_clamp;
   logic [CW-1:0] prev_cnt;
   logic          prev_valid, dir_up, dir_valid;
   logic          raw, step_up, step_dn, at_turn, viol, hold_off;

   always_comb begin
      duty_clamp = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
      raw        = ({1'b0, cnt_in} < duty_act);
      step_up    = ({1'b0, cnt_in} == ({1'b0, prev_cnt} + 1'b1));
      step_dn    = ({1'b0, prev_cnt} == ({1'b0, cnt_in} + 1'b1));
      at_turn    = (prev_cnt == '0) || ({1'b0, prev_cnt} == PEAK_V);
      viol       = 1'b0;
      if (prev_valid) begin
         if (({1'b0, cnt_in} > PEAK_V) || !(step_up || step_dn))
            viol = 1'b1;
         // a change of direction is only legal when turning at the valley or the peak
         else if (dir_valid && (step_up != dir_up) && !at_turn)
            viol = 1'b1;
      end
   end

`ifdef TRI_PWM_FAULT_SHUTDOWN_EN
   always_comb hold_off = seq_err;
`else
   always_comb hold_off = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_cnt     <= '0;
         prev_valid   <= 1'b0;
         dir_up       <= 1'b0;
         dir_valid    <= 1'b0;
         seq_err      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         prev_cnt     <= cnt_in;
         prev_valid   <= 1'b1;
         period_start <= (cnt_in == '0);
         seq_err      <= seq_err | viol;
         if (!prev_valid) begin
            dir_up    <= (cnt_in == '0);
            dir_valid <= (cnt_in == '0);
         end else if (step_up || step_dn) begin
            dir_up    <= step_up;
            dir_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_pend <= '0;
         duty_act  <= '0;
      end else begin
         if (duty_wr)
            duty_pend <= duty_clamp;
         if (cnt_in == '0)
            duty_act <= duty_wr ? duty_clamp : duty_pend;
      end
   end

   always_comb begin
      state_nx  = state;
      target_nx = target;
      dt_cnt_nx = dt_cnt;
      case (state)
         OFF, HIGH, LOW: begin
            // OFF always leaves; HIGH/LOW leave when raw disagrees with the driven side
            if (state == OFF || raw != (state == HIGH)) begin
               if (DT_V == '0) begin
                  state_nx = raw ? HIGH : LOW;
               end else begin
                  state_nx  = DEAD;
                  target_nx = raw;
                  dt_cnt_nx = DT_V;
               end
            end
         end
         DEAD: begin
            if (raw != target) begin
               target_nx = raw;
               dt_cnt_nx = DT_V;
            end else if (dt_cnt <= 3'd1) begin
               state_nx = target ? HIGH : LOW;
            end else begin
               dt_cnt_nx = dt_cnt - 3'd1;
            end
         end
         default: state_nx = OFF;
      endcase
      if (hold_off)
         state_nx = OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= OFF;
         target <= 1'b0;
         dt_cnt <= '0;
         pwm_h  <= 1'b0;
         pwm_l  <= 1'b0;
      end else begin
         state  <= state_nx;
         target <= target_nx;
         dt_cnt <= dt_cnt_nx;
         pwm_h  <= (state == HIGH) && !hold_off;
         pwm_l  <= (state == LOW) && !hold_off;
      end
   end

endmodule

// File: tb/tb_tri_pwm_deadtime.sv
// Bench for tri_pwm_deadtime: vector table through a scoreboard queue, plus hand sequences on a DT=2 instance.
module tb_tri_pwm_deadtime;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] cnt_in = '0;
   logic [3:0] duty_in = '0;
   logic       duty_wr = 1'b0;
   logic       h1, l1, ps1, err1, h2, l2, ps2, err2;
   int         checks = 0;
   int         errors = 0;
   int         step_no = 0;

`ifdef TRI_PWM_FAULT_SHUTDOWN_EN
   localparam bit SHUT = 1'b1;
`else
   localparam bit SHUT = 1'b0;
`endif

   tri_pwm_deadtime #(.CW(3), .PEAK(3), .DT(1)) u_dt1 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .duty_in(duty_in), .duty_wr(duty_wr),
      .pwm_h(h1), .pwm_l(l1), .period_start(ps1), .seq_err(err1));

   tri_pwm_deadtime #(.CW(3), .PEAK(3), .DT(2)) u_dt2 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .duty_in(duty_in), .duty_wr(duty_wr),
      .pwm_h(h2), .pwm_l(l2), .period_start(ps2), .seq_err(err2));

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [2:0] cnt;
      logic       wr;
      logic [3:0] din;
      logic       sel;
      logic       chk_pwm;
      logic       h, l, ps, err;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(input int r, input int c, input int w, input int d, input int s,
                               input int chk, input int h, input int l, input int ps, input int err);
      vec_t v;
      v.rst = r[0]; v.cnt = c[2:0]; v.wr = w[0]; v.din = d[3:0]; v.sel = s[0];
      v.chk_pwm = chk[0]; v.h = h[0]; v.l = l[0]; v.ps = ps[0]; v.err = err[0];
      return v;
   endfunction

   function automatic void row(input int r, input int c, input int w, input int d, input int chk,
                               input int h, input int l, input int ps, input int err);
      tbl.push_back(mk(r, c, w, d, 0, chk, h, l, ps, err));
   endfunction

   function automatic void rs();
      row(1, 0, 0, 0, 1, 0, 0, 0, 0);
   endfunction

   function automatic void pw(input int c, input int h, input int l, input int ps);
      row(0, c, 0, 0, 1, h, l, ps, 0);
   endfunction

   function automatic void sq(input int c, input int ps, input int err);
      row(0, c, 0, 0, 0, 0, 0, ps, err);
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: actual %0b, expected %0b", name, step_no, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      logic ah, al, aps, aerr;
      @(negedge clk);
      rst = v.rst; cnt_in = v.cnt; duty_wr = v.wr; duty_in = v.din;
      sb.push_back(v);
      @(posedge clk);
      #1;
      step_no++;
      e = sb.pop_front();
      if (e.sel) begin ah = h2; al = l2; aps = ps2; aerr = err2; end
      else       begin ah = h1; al = l1; aps = ps1; aerr = err1; end
      chk("period_start", aps, e.ps);
      chk("seq_err", aerr, e.err);
      if (e.chk_pwm) begin
         chk("pwm_h", ah, e.h);
         chk("pwm_l", al, e.l);
      end
   endtask

   always @(negedge clk) begin
      checks++;
      if ((h1 && l1) || (h2 && l2)) begin
         errors++;
         $display("FAIL overlap at %0t: dt1 h/l %0b%0b, dt2 h/l %0b%0b, required never both 1", $time, h1, l1, h2, l2);
      end
   end

   initial begin
      // basic PWM (duty 2), shadowed write at count 2, write coinciding with the valley, reset mid-DEAD
      rs(); rs();
      row(0, 2, 1, 2, 1, 0, 0, 0, 0);
      pw(1,0,0,0); pw(0,0,1,1); pw(1,0,1,0); pw(2,0,0,0); pw(3,0,0,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,0,1);
      pw(1,1,0,0); pw(2,1,0,0); pw(3,0,0,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,0,1); pw(1,1,0,0);
      row(0, 2, 1, 3, 1, 1, 0, 0, 0);
      pw(3,0,0,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,0,1); pw(1,1,0,0); pw(2,1,0,0); pw(3,1,0,0); pw(2,0,0,0); pw(1,0,0,0);
      row(0, 0, 1, 1, 1, 1, 0, 1, 0);
      pw(1,1,0,0); pw(2,0,0,0); pw(3,0,1,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,1,1); pw(1,0,0,0); pw(2,0,0,0); pw(3,0,1,0);
      pw(2,0,1,0); pw(1,0,1,0); pw(0,0,1,1);
      row(1, 1, 0, 0, 1, 0, 0, 0, 0);
      pw(0,0,0,1); pw(1,0,0,0); pw(2,0,1,0);
      // duty 0 then a write of 7 clamped to 4
      rs();
      row(0, 0, 1, 0, 1, 0, 0, 1, 0);
      pw(1,0,0,0); pw(2,0,1,0); pw(3,0,1,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,1,1);
      row(0, 1, 1, 7, 1, 0, 1, 0, 0);
      pw(2,0,1,0); pw(3,0,1,0); pw(2,0,1,0); pw(1,0,1,0); pw(0,0,1,1); pw(1,0,1,0); pw(2,0,0,0);
      pw(3,1,0,0); pw(2,1,0,0); pw(1,1,0,0); pw(0,1,0,1); pw(1,1,0,0);
      // sequence error while driving high: shutdown build goes dark, default build keeps running
      rs();
      row(0, 0, 1, 9, 1, 0, 0, 1, 0);
      pw(1,0,0,0); pw(2,0,0,0);
      row(0, 0, 0, 0, 1, 1, 0, 1, 1);
      row(0, 1, 0, 0, 1, SHUT ? 0 : 1, 0, 0, 1);
      row(0, 2, 0, 0, 1, SHUT ? 0 : 1, 0, 0, 1);
      row(0, 3, 0, 0, 1, SHUT ? 0 : 1, 0, 0, 1);
      // jump 1->3, reversal below peak, repeated zero, legal turns from an unseeded start, overrange
      rs(); sq(0,1,0); sq(1,0,0); sq(3,0,1); sq(2,0,1); sq(1,0,1); sq(0,1,1);
      rs(); sq(0,1,0); sq(1,0,0); sq(2,0,0); sq(1,0,1); sq(2,0,1);
      rs(); sq(0,1,0); sq(0,1,1);
      rs(); sq(3,0,0); sq(2,0,0); sq(1,0,0); sq(0,1,0); sq(1,0,0); sq(2,0,0); sq(3,0,0); sq(2,0,0);
      rs(); sq(1,0,0); sq(2,0,0); sq(3,0,0); sq(4,0,1);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // DT=2: raw flips back during DEAD and the counter restarts, then reset lands mid-DEAD
      apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 3, 0, 0, 1, 1, 0, 1, 0, 0));
      apply(mk(0, 2, 0, 0, 1, 1, 0, 1, 0, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 1, 0, 0));
      apply(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 3, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 0, 1, 1, 0, 1, 0, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 1, 0, 0));
      apply(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(1, 2, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
      apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 2, 0, 0, 1, 1, 0, 0, 0, 0));
      apply(mk(0, 3, 0, 0, 1, 1, 0, 1, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
